alu: RTL and testbench

- 8-bit registered arithmetic/logic unit: two operands, 3-bit operation select, result plus carry, zero, sign and overflow flags.
- Used as the datapath execute block; inputs are sampled every clock and result/flags are presented one cycle later.
- Clocking: one clock; reset is synchronous and active-high (ports clk, rst).

---
 rtl/alu.sv | 99 +++++++++
 tb/tb_alu.sv | 104 ++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 8-bit ALU: eight operations, result and C/Z/S/V flags
// presented one clock after the operands are sampled.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       operator,
    output logic [WIDTH-1:0] res,
    output logic             c_flag,
    output logic             z_flag,
    output logic             s_flag,
    output logic             ov_flag
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_LSL = 3'b110,
        OP_LSR = 3'b111
    } op_e;

    logic [WIDTH-1:0] res_d, res_q;
    logic             c_d, c_q;
    logic             z_d, z_q;
    logic             s_d, s_q;
    logic             ov_d, ov_q;

    // The extra top bit holds the carry-out for ADD and the borrow for SUB.
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;

    assign sum_w  = {1'b0, op1} + {1'b0, op2};
    assign diff_w = {1'b0, op1} - {1'b0, op2};

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        ov_d  = 1'b0;
        case (op_e'(operator))
            OP_ADD: begin
                res_d = sum_w[WIDTH-1:0];
                c_d   = sum_w[WIDTH];
                ov_d  = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                        (sum_w[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff_w[WIDTH-1:0];
                c_d   = diff_w[WIDTH];
                ov_d  = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                        (diff_w[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND: res_d = op1 & op2;
            OP_OR:  res_d = op1 | op2;
            OP_XOR: res_d = op1 ^ op2;
            OP_NOT: res_d = ~op1;
            OP_LSL: begin
                res_d = {op1[WIDTH-2:0], 1'b0};
                c_d   = op1[WIDTH-1];
            end
            OP_LSR: begin
                res_d = {1'b0, op1[WIDTH-1:1]};
                c_d   = op1[0];
            end
            default: res_d = '0;
        endcase
        z_d = (res_d == '0);
        s_d = res_d[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            s_q   <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            res_q <= res_d;
            c_q   <= c_d;
            z_q   <= z_d;
            s_q   <= s_d;
            ov_q  <= ov_d;
        end
    end

    assign res     = res_q;
    assign c_flag  = c_q;
    assign z_flag  = z_q;
    assign s_flag  = s_q;
    assign ov_flag = ov_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: outputs are packed as {res, c, z, s, ov}
// and compared against hand-computed values one edge after each input change.
module tb_alu;

    localparam int WIDTH = 8;
    localparam int OW    = WIDTH + 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       operator;
    logic [WIDTH-1:0] res;
    logic             c_flag, z_flag, s_flag, ov_flag;

    int n_checks = 0;
    int n_fail   = 0;
    logic [OW-1:0] prev_exp;

    alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .op1      (op1),
        .op2      (op2),
        .operator (operator),
        .res      (res),
        .c_flag   (c_flag),
        .z_flag   (z_flag),
        .s_flag   (s_flag),
        .ov_flag  (ov_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] observed();
        return {res, c_flag, z_flag, s_flag, ov_flag};
    endfunction

    task automatic check_eq(input string tag, input logic [OW-1:0] obs,
                            input logic [OW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got res=%h czsv=%b, expected res=%h czsv=%b",
                     tag, obs[OW-1:4], obs[3:0], exp[OW-1:4], exp[3:0]);
        end
    endtask

    // Apply one vector just after an edge; before the next edge the previous
    // result must still be held, and right after it the new one must appear.
    task automatic apply(input string tag, input logic r, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_res, input logic [3:0] exp_czsv);
        rst      = r;
        operator = op;
        op1      = a;
        op2      = b;
        @(negedge clk);
        check_eq({tag, "_hold"}, observed(), prev_exp);
        @(posedge clk);
        #1;
        check_eq(tag, observed(), {exp_res, exp_czsv});
        prev_exp = {exp_res, exp_czsv};
    endtask

    initial begin
        rst      = 1'b1;
        operator = 3'b000;
        op1      = 8'h11;
        op2      = 8'h22;
        @(posedge clk);
        #1;
        check_eq("reset", observed(), '0);
        prev_exp = '0;

        //      tag          rst  op      op1    op2    res    czsv
        apply("add_50_70",   0, 3'b000, 8'd50, 8'd70, 8'd120, 4'b0000);
        apply("add_127_1",   0, 3'b000, 8'h7F, 8'h01, 8'h80,  4'b0011);
        apply("add_ff_01",   0, 3'b000, 8'hFF, 8'h01, 8'h00,  4'b1100);
        apply("add_80_80",   0, 3'b000, 8'h80, 8'h80, 8'h00,  4'b1101);
        apply("sub_100_50",  0, 3'b001, 8'd100, 8'd50, 8'd50, 4'b0000);
        apply("sub_5_10",    0, 3'b001, 8'd5,  8'd10, 8'd251, 4'b1010);
        apply("sub_7f_ff",   0, 3'b001, 8'h7F, 8'hFF, 8'h80,  4'b1011);
        apply("sub_equal",   0, 3'b001, 8'h40, 8'h40, 8'h00,  4'b0100);
        apply("and",         0, 3'b010, 8'hF0, 8'h0F, 8'h00,  4'b0100);
        apply("or",          0, 3'b011, 8'hF0, 8'h0F, 8'hFF,  4'b0010);
        apply("xor",         0, 3'b100, 8'hAA, 8'h55, 8'hFF,  4'b0010);
        apply("not",         0, 3'b101, 8'h0F, 8'h33, 8'hF0,  4'b0010);
        apply("lsl_81",      0, 3'b110, 8'h81, 8'hFF, 8'h02,  4'b1000);
        apply("lsr_81",      0, 3'b111, 8'h81, 8'hFF, 8'h40,  4'b1000);
        apply("lsl_40",      0, 3'b110, 8'h40, 8'h00, 8'h80,  4'b0010);
        apply("lsr_01",      0, 3'b111, 8'h01, 8'h00, 8'h00,  4'b1100);
        apply("add_after",   0, 3'b000, 8'h7F, 8'h01, 8'h80,  4'b0011);
        apply("rst_mid",     1, 3'b000, 8'h7F, 8'h01, 8'h00,  4'b0000);
        apply("rst_resume",  0, 3'b000, 8'h01, 8'h02, 8'h03,  4'b0000);
        apply("and_resume",  0, 3'b010, 8'hC3, 8'h81, 8'h81,  4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
